// File: rtl/exc_seq_if.sv
// Bundle between the pipeline/CP0 and the exception sequencer.
// The master drives M-stage and CP0 state; the slave returns flush, redirect and CP0 update strobes.
interface exc_seq_if;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_bd;
  logic [4:0]  m_exccode;
  logic        m_eret;
  logic [5:0]  hw_int;
  logic [5:0]  sr_im;
  logic        sr_ie;
  logic        sr_exl;
  logic [31:0] epc_in;

  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        cp0_exc_we;
  logic [4:0]  cp0_exccode;
  logic [31:0] cp0_epc;
  logic        cp0_bd;
  logic        exl_clr;
  logic        busy;

  modport master (
    output m_valid, m_pc, m_bd, m_exccode, m_eret, hw_int, sr_im, sr_ie, sr_exl, epc_in,
    input  flush, redirect, redirect_pc, cp0_exc_we, cp0_exccode, cp0_epc, cp0_bd, exl_clr, busy
  );

  modport slave (
    input  m_valid, m_pc, m_bd, m_exccode, m_eret, hw_int, sr_im, sr_ie, sr_exl, epc_in,
    output flush, redirect, redirect_pc, cp0_exc_we, cp0_exccode, cp0_epc, cp0_bd, exl_clr, busy
  );
endinterface

// File: rtl/exc_seq_ctrl.sv
// Exception/interrupt/ERET sequencer: takes one M-stage event, redirects the PC,
// updates CP0, then flushes the pipeline for a fixed drain period.
module exc_seq_ctrl #(
  parameter logic [31:0] HANDLER_PC   = 32'h0000_4180,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input logic      clk,
  input logic      reset,
  exc_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StTake, StEret, StDrain} state_e;

  localparam logic [2:0] DrainLoad = 3'(DRAIN_CYCLES);

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic        int_req;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] take_epc;

  assign int_req  = (|(bus.hw_int & bus.sr_im)) & bus.sr_ie & ~bus.sr_exl & bus.m_valid;
  assign exc_req  = bus.m_valid & (bus.m_exccode != 5'd0);
  assign eret_req = bus.m_valid & bus.m_eret;

  // A delay-slot instruction restarts at its branch, one word earlier.
  always_comb begin
    take_epc = {bus.m_pc[31:2], 2'b00};
    if (bus.m_bd) begin
      take_epc = take_epc - 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      cnt_q           <= 3'd0;
      bus.flush       <= 1'b0;
      bus.redirect    <= 1'b0;
      bus.redirect_pc <= '0;
      bus.cp0_exc_we  <= 1'b0;
      bus.cp0_exccode <= '0;
      bus.cp0_epc     <= '0;
      bus.cp0_bd      <= 1'b0;
      bus.exl_clr     <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      // Strobes and CP0 values last exactly one cycle.
      bus.redirect    <= 1'b0;
      bus.redirect_pc <= '0;
      bus.cp0_exc_we  <= 1'b0;
      bus.cp0_exccode <= '0;
      bus.cp0_epc     <= '0;
      bus.cp0_bd      <= 1'b0;
      bus.exl_clr     <= 1'b0;
      case (state_q)
        StIdle: begin
          if (int_req || exc_req) begin
            state_q         <= StTake;
            bus.flush       <= 1'b1;
            bus.busy        <= 1'b1;
            bus.redirect    <= 1'b1;
            bus.redirect_pc <= HANDLER_PC;
            bus.cp0_exc_we  <= 1'b1;
            bus.cp0_exccode <= int_req ? 5'd0 : bus.m_exccode;
            bus.cp0_epc     <= take_epc;
            bus.cp0_bd      <= bus.m_bd;
          end else if (eret_req) begin
            state_q         <= StEret;
            bus.flush       <= 1'b1;
            bus.busy        <= 1'b1;
            bus.redirect    <= 1'b1;
            bus.redirect_pc <= bus.epc_in;
            bus.exl_clr     <= 1'b1;
          end
        end
        StTake, StEret: begin
          state_q <= StDrain;
          cnt_q   <= DrainLoad;
        end
        StDrain: begin
          if (cnt_q <= 3'd1) begin
            state_q   <= StIdle;
            cnt_q     <= 3'd0;
            bus.flush <= 1'b0;
            bus.busy  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: begin
          state_q   <= StIdle;
          cnt_q     <= 3'd0;
          bus.flush <= 1'b0;
          bus.busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_seq_ctrl.sv
// Directed bench for exc_seq_ctrl: a vector table of single events plus
// hand-written drain, re-trigger and reset-abort sequences.
module tb_exc_seq_ctrl;

  localparam logic [31:0] HPC   = 32'h0000_4180;
  localparam int unsigned DRAIN = 2;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  exc_seq_if bus ();

  exc_seq_ctrl #(
    .HANDLER_PC  (HPC),
    .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  code;
    logic        eret;
    logic [5:0]  hw;
    logic [5:0]  im;
    logic        ie;
    logic        exl;
    logic [31:0] epc_in;
    logic        ev;
    logic        e_we;
    logic [4:0]  e_code;
    logic [31:0] e_epc;
    logic        e_bd;
    logic        e_clr;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    bus.m_valid   = 1'b0;
    bus.m_pc      = '0;
    bus.m_bd      = 1'b0;
    bus.m_exccode = '0;
    bus.m_eret    = 1'b0;
    bus.hw_int    = '0;
    bus.sr_im     = '0;
    bus.sr_ie     = 1'b0;
    bus.sr_exl    = 1'b0;
    bus.epc_in    = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " flush"}, 32'(bus.flush), 32'd0);
    chk({tag, " busy"}, 32'(bus.busy), 32'd0);
    chk({tag, " redirect"}, 32'(bus.redirect), 32'd0);
    chk({tag, " redirect_pc"}, bus.redirect_pc, 32'd0);
    chk({tag, " cp0_exc_we"}, 32'(bus.cp0_exc_we), 32'd0);
    chk({tag, " cp0_exccode"}, 32'(bus.cp0_exccode), 32'd0);
    chk({tag, " cp0_epc"}, bus.cp0_epc, 32'd0);
    chk({tag, " cp0_bd"}, 32'(bus.cp0_bd), 32'd0);
    chk({tag, " exl_clr"}, 32'(bus.exl_clr), 32'd0);
  endtask

  task automatic drive_int(input logic [31:0] pc);
    bus.m_valid = 1'b1;
    bus.m_pc    = pc;
    bus.hw_int  = 6'b000001;
    bus.sr_im   = 6'b000001;
    bus.sr_ie   = 1'b1;
  endtask

  // Drain cycles after the redirect cycle: flush only, then idle.
  task automatic chk_drain(input string tag);
    for (int d = 0; d < int'(DRAIN); d++) begin
      @(negedge clk);
      chk($sformatf("%s drain%0d flush", tag, d), 32'(bus.flush), 32'd1);
      chk($sformatf("%s drain%0d busy", tag, d), 32'(bus.busy), 32'd1);
      chk($sformatf("%s drain%0d redirect", tag, d), 32'(bus.redirect), 32'd0);
      chk($sformatf("%s drain%0d exc_we", tag, d), 32'(bus.cp0_exc_we), 32'd0);
      chk($sformatf("%s drain%0d exl_clr", tag, d), 32'(bus.exl_clr), 32'd0);
    end
    @(negedge clk);
    chk_zero({tag, " idle"});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    set_idle();

    //        valid pc            bd code  eret hw        im        ie exl epc_in
    //        ev we code  epc           bd clr rpc
    vecs[0]  = '{1, 32'h3008, 0, 5'd0, 0, 6'b000001, 6'b000001, 1, 0, 32'h0,
                 1, 1, 5'd0, 32'h3008, 0, 0, HPC};
    vecs[1]  = '{1, 32'h3010, 1, 5'd12, 0, 6'b0, 6'b0, 0, 0, 32'h0,
                 1, 1, 5'd12, 32'h300C, 1, 0, HPC};
    vecs[2]  = '{1, 32'h3100, 0, 5'd0, 1, 6'b0, 6'b0, 0, 1, 32'h3020,
                 1, 0, 5'd0, 32'h0, 0, 1, 32'h3020};
    vecs[3]  = '{1, 32'h4000, 0, 5'd4, 1, 6'b000001, 6'b000001, 1, 0, 32'h3020,
                 1, 1, 5'd0, 32'h4000, 0, 0, HPC};
    vecs[4]  = '{0, 32'h3008, 0, 5'd10, 1, 6'b000001, 6'b000001, 1, 0, 32'h3020,
                 0, 0, 5'd0, 32'h0, 0, 0, 32'h0};
    vecs[5]  = '{1, 32'h5006, 0, 5'd8, 0, 6'b000001, 6'b000001, 1, 1, 32'h0,
                 1, 1, 5'd8, 32'h5004, 0, 0, HPC};
    vecs[6]  = '{1, 32'h3008, 0, 5'd0, 0, 6'b000001, 6'b000001, 0, 0, 32'h0,
                 0, 0, 5'd0, 32'h0, 0, 0, 32'h0};
    vecs[7]  = '{1, 32'h3008, 0, 5'd0, 0, 6'b000001, 6'b000001, 1, 1, 32'h0,
                 0, 0, 5'd0, 32'h0, 0, 0, 32'h0};
    vecs[8]  = '{1, 32'h3008, 0, 5'd0, 0, 6'b100000, 6'b011111, 1, 0, 32'h0,
                 0, 0, 5'd0, 32'h0, 0, 0, 32'h0};
    vecs[9]  = '{1, 32'h0000_0002, 1, 5'd5, 0, 6'b0, 6'b0, 0, 0, 32'h0,
                 1, 1, 5'd5, 32'hFFFF_FFFC, 1, 0, HPC};
    vecs[10] = '{1, 32'h1000, 0, 5'd3, 1, 6'b0, 6'b0, 0, 0, 32'h2000,
                 1, 1, 5'd3, 32'h1000, 0, 0, HPC};
    vecs[11] = '{1, 32'h2000, 1, 5'd0, 0, 6'b100000, 6'b100000, 1, 0, 32'h0,
                 1, 1, 5'd0, 32'h1FFC, 1, 0, HPC};

    // Reset: outputs low while reset is sampled and after release.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    chk_zero("post_reset");

    for (int i = 0; i < 12; i++) begin
      bus.m_valid   = vecs[i].valid;
      bus.m_pc      = vecs[i].pc;
      bus.m_bd      = vecs[i].bd;
      bus.m_exccode = vecs[i].code;
      bus.m_eret    = vecs[i].eret;
      bus.hw_int    = vecs[i].hw;
      bus.sr_im     = vecs[i].im;
      bus.sr_ie     = vecs[i].ie;
      bus.sr_exl    = vecs[i].exl;
      bus.epc_in    = vecs[i].epc_in;
      @(negedge clk);
      set_idle();
      chk($sformatf("v%0d flush", i), 32'(bus.flush), 32'(vecs[i].ev));
      chk($sformatf("v%0d busy", i), 32'(bus.busy), 32'(vecs[i].ev));
      chk($sformatf("v%0d redirect", i), 32'(bus.redirect), 32'(vecs[i].ev));
      chk($sformatf("v%0d redirect_pc", i), bus.redirect_pc, vecs[i].e_rpc);
      chk($sformatf("v%0d cp0_exc_we", i), 32'(bus.cp0_exc_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d cp0_exccode", i), 32'(bus.cp0_exccode), 32'(vecs[i].e_code));
      chk($sformatf("v%0d cp0_epc", i), bus.cp0_epc, vecs[i].e_epc);
      chk($sformatf("v%0d cp0_bd", i), 32'(bus.cp0_bd), 32'(vecs[i].e_bd));
      chk($sformatf("v%0d exl_clr", i), 32'(bus.exl_clr), 32'(vecs[i].e_clr));
      if (vecs[i].ev) chk_drain($sformatf("v%0d", i));
    end

    // Exception re-pulsed during TAKE/DRAIN is dropped, not queued.
    bus.m_valid   = 1'b1;
    bus.m_pc      = 32'h3040;
    bus.m_exccode = 5'd10;
    @(negedge clk);
    chk("repulse take exc_we", 32'(bus.cp0_exc_we), 32'd1);
    chk("repulse take code", 32'(bus.cp0_exccode), 32'd10);
    @(negedge clk);
    chk("repulse d0 flush", 32'(bus.flush), 32'd1);
    chk("repulse d0 exc_we", 32'(bus.cp0_exc_we), 32'd0);
    @(negedge clk);
    chk("repulse d1 flush", 32'(bus.flush), 32'd1);
    chk("repulse d1 exc_we", 32'(bus.cp0_exc_we), 32'd0);
    set_idle();
    @(negedge clk);
    chk_zero("repulse idle");
    @(negedge clk);
    chk_zero("repulse idle2");

    // Interrupt held high is taken again once back in idle.
    drive_int(32'h3008);
    @(negedge clk);
    chk("sticky first exc_we", 32'(bus.cp0_exc_we), 32'd1);
    @(negedge clk);
    chk("sticky d0 exc_we", 32'(bus.cp0_exc_we), 32'd0);
    @(negedge clk);
    chk("sticky d1 exc_we", 32'(bus.cp0_exc_we), 32'd0);
    chk("sticky d1 flush", 32'(bus.flush), 32'd1);
    @(negedge clk);
    chk("sticky idle busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    set_idle();
    chk("sticky second exc_we", 32'(bus.cp0_exc_we), 32'd1);
    chk("sticky second epc", bus.cp0_epc, 32'h3008);
    chk_drain("sticky second");

    // Reset mid-drain aborts with no further strobes.
    bus.m_valid   = 1'b1;
    bus.m_pc      = 32'h3050;
    bus.m_exccode = 5'd4;
    @(negedge clk);
    set_idle();
    chk("rst_drain take exc_we", 32'(bus.cp0_exc_we), 32'd1);
    @(negedge clk);
    chk("rst_drain d0 flush", 32'(bus.flush), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("rst_drain reset");
    reset = 1'b0;
    @(negedge clk);
    chk_zero("rst_drain after1");
    @(negedge clk);
    chk_zero("rst_drain after2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
